// File: rtl/instr_dispatch.sv
// Purpose: decodes the aux instruction stream and routes each word to one of NUM_ENG engine queues; handles BARRIER/END, tracks per-engine outstanding work.
// Latency: an accepted word is presented on m_eng_* the cycle after acceptance; peak rate 1 instruction per 2 cycles.
// Backpressure: s_instr_tready low while an issue is pending or a barrier drains; engine valid/data held until ready, withheld while that engine's count is saturated.
// Optional feature macro: INSTR_DISPATCH_PERF_EN adds perf_stall_cnt and perf_barrier_cnt.
module instr_dispatch #(
   parameter int INSTR_WIDTH = 128,
   parameter int NUM_ENG     = 4,
   parameter int OPC_WIDTH   = 4,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   s_instr_tready,
   input  logic                   s_instr_tvalid,
   input  logic [INSTR_WIDTH-1:0] s_instr_tdata,
   output logic [NUM_ENG-1:0]     m_eng_tvalid,
   input  logic [NUM_ENG-1:0]     m_eng_tready,
   output logic [INSTR_WIDTH-1:0] m_eng_tdata,
   input  logic [NUM_ENG-1:0]     eng_done,
   output logic                   end_pulse,
   output logic                   busy,
   output logic [31:0]            issued_cnt,
   output logic [15:0]            err_cnt
`ifdef INSTR_DISPATCH_PERF_EN
   ,
   output logic [NUM_ENG*32-1:0]  perf_stall_cnt,
   output logic [31:0]            perf_barrier_cnt
`endif
);

   localparam int ENG_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam logic [OPC_WIDTH-1:0] OPC_BAR = {OPC_WIDTH{1'b1}};
   localparam logic [OPC_WIDTH-1:0] OPC_END = {OPC_WIDTH{1'b1}} - OPC_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [NUM_ENG-1:0]   ENG_ONE = NUM_ENG'(1);

   typedef enum logic [1:0] {ST_FETCH, ST_ISSUE, ST_BARRIER} state_t;

   state_t                            state_q;
   logic                              tready_q;
   logic [NUM_ENG-1:0]                vld_q;
   logic [INSTR_WIDTH-1:0]            hold_q;
   logic [ENG_W-1:0]                  eng_q;
   logic                              end_q;
   logic [31:0]                       issued_q;
   logic [15:0]                       err_q, err_d;
   logic [NUM_ENG-1:0][CNT_WIDTH-1:0] outst_q, outst_d;

   logic                 accept;
   logic [OPC_WIDTH-1:0] opc;
   logic                 opc_eng, opc_end, opc_bar, opc_ill;
   logic [ENG_W-1:0]     opc_idx;
   logic [NUM_ENG-1:0]   iss_hs;
   logic                 all_idle;
   logic [31:0]          under_cnt, err_inc, err_sum;

   assign accept   = tready_q & s_instr_tvalid;
   assign opc      = s_instr_tdata[OPC_WIDTH-1:0];
   assign iss_hs   = vld_q & m_eng_tready;
   assign all_idle = (outst_q == '0);

   // Opcode classification of the word currently on the input bus
   always_comb begin
      opc_eng = (opc != '0) && (32'(opc) <= 32'(NUM_ENG));
      opc_end = (opc == OPC_END);
      opc_bar = (opc == OPC_BAR);
      opc_ill = (opc != '0) && !opc_eng && !opc_end && !opc_bar;
      opc_idx = ENG_W'(32'(opc) - 32'd1);
   end

   // Outstanding-count update: issue and done on the same engine cancel; done on an empty count is an error
   always_comb begin
      outst_d   = outst_q;
      under_cnt = '0;
      for (int k = 0; k < NUM_ENG; k++) begin
         if (iss_hs[k] && !eng_done[k]) begin
            outst_d[k] = outst_q[k] + CNT_WIDTH'(1);
         end else if (!iss_hs[k] && eng_done[k]) begin
            if (outst_q[k] == '0) begin
               under_cnt = under_cnt + 32'd1;
            end else begin
               outst_d[k] = outst_q[k] - CNT_WIDTH'(1);
            end
         end
      end
   end

   // Error counter next value: all sources in a cycle add together, saturating at all-ones
   always_comb begin
      err_inc = under_cnt + 32'(accept & opc_ill);
      err_sum = 32'(err_q) + err_inc;
      err_d   = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
   end

   // Dispatch FSM: accept/decode in FETCH, hold one engine request in ISSUE, drain in BARRIER
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         tready_q <= 1'b0;
         vld_q    <= '0;
         hold_q   <= '0;
         eng_q    <= '0;
         end_q    <= 1'b0;
      end else begin
         end_q <= 1'b0;
         unique case (state_q)
            ST_FETCH: begin
               tready_q <= 1'b1;
               if (accept) begin
                  hold_q <= s_instr_tdata;
                  if (opc_eng) begin
                     state_q  <= ST_ISSUE;
                     tready_q <= 1'b0;
                     eng_q    <= opc_idx;
                     // a saturated engine gets no valid until one of its dones frees a slot
                     vld_q    <= (outst_d[opc_idx] != CNT_MAX) ? (ENG_ONE << opc_idx) : '0;
                  end else if (opc_bar) begin
                     state_q  <= ST_BARRIER;
                     tready_q <= 1'b0;
                  end else if (opc_end) begin
                     end_q <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (iss_hs != '0) begin
                  state_q  <= ST_FETCH;
                  tready_q <= 1'b1;
                  vld_q    <= '0;
               end else if ((vld_q == '0) && (outst_d[eng_q] != CNT_MAX)) begin
                  vld_q <= ENG_ONE << eng_q;
               end
            end
            ST_BARRIER: begin
               if (all_idle) begin
                  state_q  <= ST_FETCH;
                  tready_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_FETCH;
               tready_q <= 1'b0;
               vld_q    <= '0;
            end
         endcase
      end
   end

   // Bookkeeping counters: outstanding per engine, issued total (wraps), errors (saturating)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_q  <= '0;
         issued_q <= '0;
         err_q    <= '0;
      end else begin
         outst_q <= outst_d;
         err_q   <= err_d;
         if (iss_hs != '0) begin
            issued_q <= issued_q + 32'd1;
         end
      end
   end

`ifdef INSTR_DISPATCH_PERF_EN
   logic [NUM_ENG-1:0][31:0] stall_q;
   logic [31:0]              bar_cyc_q;

   // Performance counters: cycles an issue waits on its engine, cycles spent draining a barrier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q   <= '0;
         bar_cyc_q <= '0;
      end else begin
         if ((state_q == ST_ISSUE) && (iss_hs == '0)) begin
            stall_q[eng_q] <= stall_q[eng_q] + 32'd1;
         end
         if (state_q == ST_BARRIER) begin
            bar_cyc_q <= bar_cyc_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt   = stall_q;
   assign perf_barrier_cnt = bar_cyc_q;
`endif

   assign s_instr_tready = tready_q;
   assign m_eng_tvalid   = vld_q;
   assign m_eng_tdata    = hold_q;
   assign end_pulse      = end_q;
   assign busy           = (state_q != ST_FETCH) || !all_idle;
   assign issued_cnt     = issued_q;
   assign err_cnt        = err_q;

endmodule
